// File: rtl/commit_trace_fifo.sv
// ============================================================================
// Module      : commit_trace_fifo
// Description : Armable/triggerable capture buffer for retired-instruction
//               records, read out as four DATA_W-wide beats per record.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module commit_trace_fifo #(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 16,
    parameter logic [31:0] PC_BASE   = 32'h00400000,
    parameter bit          OVERWRITE = 1'b0
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   trig_en,
    input  logic [DATA_W-1:0]      trig_pc,
    input  logic                   commit_valid,
    input  logic [DATA_W-1:0]      commit_pc,
    input  logic [DATA_W-1:0]      commit_inst,
    input  logic                   commit_wen,
    input  logic [4:0]             commit_waddr,
    input  logic [DATA_W-1:0]      commit_wdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [1:0]             out_beat,
    output logic [$clog2(DEPTH):0] count,
    output logic [15:0]            dropped,
    output logic [1:0]             state
);

    localparam int                C_PTR_W   = $clog2(DEPTH);
    localparam int                C_CNT_W   = C_PTR_W + 1;
    localparam logic [DATA_W-1:0] C_PC_BASE = DATA_W'(PC_BASE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t               state_q,   state_d;
    logic [C_PTR_W-1:0]   wr_ptr_q,  wr_ptr_d;
    logic [C_PTR_W-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [C_CNT_W-1:0]   count_q,   count_d;
    logic [15:0]          dropped_q, dropped_d;
    logic [1:0]           beat_q,    beat_d;

    logic [DATA_W-1:0]    pc_mem    [DEPTH];
    logic [DATA_W-1:0]    inst_mem  [DEPTH];
    logic                 wen_mem   [DEPTH];
    logic [4:0]           waddr_mem [DEPTH];
    logic [DATA_W-1:0]    wdata_mem [DEPTH];

    logic                 w_full;
    logic                 w_accept;
    logic                 w_pop;
    logic                 w_capture;
    logic                 w_wr_en;
    logic                 w_ovr;
    logic                 w_drop;
    logic [DATA_W-1:0]    w_beat2;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        dropped_d = dropped_q;
        beat_d    = beat_q;
        w_wr_en   = 1'b0;
        w_ovr     = 1'b0;
        w_drop    = 1'b0;
        w_full    = (count_q == C_CNT_W'(DEPTH));
        w_accept  = (count_q != '0) && out_ready;
        w_pop     = w_accept && (beat_q == 2'd3);
        w_capture = commit_valid &&
                    ((state_q == ST_CAPTURE) ||
                     ((state_q == ST_ARMED) && (commit_pc == trig_pc)));

        if (arm) begin
            // A new session discards everything, including any same-cycle commit or beat.
            state_d   = trig_en ? ST_ARMED : ST_CAPTURE;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            dropped_d = '0;
            beat_d    = 2'd0;
        end else begin
            if (w_accept) begin
                beat_d = beat_q + 2'd1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
            end
            if (w_capture) begin
                if (state_q == ST_ARMED) begin
                    state_d = ST_CAPTURE;
                end
                if (!w_full || w_pop) begin
                    w_wr_en = 1'b1;
                end else if (OVERWRITE) begin
                    // Oldest record is replaced; any partial readout of it restarts.
                    w_wr_en  = 1'b1;
                    w_ovr    = 1'b1;
                    w_drop   = 1'b1;
                    rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
                    beat_d   = 2'd0;
                end else begin
                    w_drop  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            if ((state_q == ST_DONE) && commit_valid) begin
                w_drop = 1'b1;
            end
            if (w_wr_en) begin
                wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
            end
            if (w_wr_en && !w_ovr && !w_pop) begin
                count_d = count_q + C_CNT_W'(1);
            end else if (!(w_wr_en && !w_ovr) && w_pop) begin
                count_d = count_q - C_CNT_W'(1);
            end
            if (w_drop && (dropped_q != 16'hFFFF)) begin
                dropped_d = dropped_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dropped_q <= '0;
            beat_q    <= 2'd0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            dropped_q <= dropped_d;
            beat_q    <= beat_d;
        end
    end

    // Record storage is deliberately left out of reset.
    always_ff @(posedge clk_in) begin
        if (w_wr_en) begin
            pc_mem[wr_ptr_q]    <= commit_pc;
            inst_mem[wr_ptr_q]  <= commit_inst;
            wen_mem[wr_ptr_q]   <= commit_wen;
            waddr_mem[wr_ptr_q] <= commit_waddr;
            wdata_mem[wr_ptr_q] <= commit_wdata;
        end
    end

    always_comb begin
        w_beat2            = '0;
        w_beat2[DATA_W-1]  = wen_mem[rd_ptr_q];
        w_beat2[4:0]       = waddr_mem[rd_ptr_q];
        case (beat_q)
            2'd0:    out_data = pc_mem[rd_ptr_q] + C_PC_BASE;
            2'd1:    out_data = inst_mem[rd_ptr_q];
            2'd2:    out_data = w_beat2;
            default: out_data = wdata_mem[rd_ptr_q];
        endcase
    end

    assign out_valid = (count_q != '0);
    assign out_beat  = beat_q;
    assign count     = count_q;
    assign dropped   = dropped_q;
    assign state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_fifo.sv
// ============================================================================
// Module      : tb_commit_trace_fifo
// Description : Directed self-checking bench; three DUT flavours share stimulus.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_commit_trace_fifo;

    logic        clk_in       = 1'b0;
    logic        reset        = 1'b0;
    logic        arm          = 1'b0;
    logic        trig_en      = 1'b0;
    logic [31:0] trig_pc      = '0;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_pc    = '0;
    logic [31:0] commit_inst  = '0;
    logic        commit_wen   = 1'b0;
    logic [4:0]  commit_waddr = '0;
    logic [31:0] commit_wdata = '0;
    logic        out_ready    = 1'b0;

    logic        ov  [3];
    logic [31:0] od  [3];
    logic [1:0]  ob  [3];
    logic [1:0]  st  [3];
    logic [15:0] dr  [3];
    logic [8:0]  cnt [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_in = ~clk_in;

    // Instance 0: DEPTH 16 stop-when-full; 1: DEPTH 4 stop; 2: DEPTH 4 overwrite.
    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int D  = (g == 0) ? 16 : 4;
            localparam int CW = $clog2(D) + 1;
            logic [CW-1:0] c;
            commit_trace_fifo #(
                .DATA_W   (32),
                .DEPTH    (D),
                .PC_BASE  (32'h00400000),
                .OVERWRITE(g == 2)
            ) u_dut (
                .clk_in      (clk_in),
                .reset       (reset),
                .arm         (arm),
                .trig_en     (trig_en),
                .trig_pc     (trig_pc),
                .commit_valid(commit_valid),
                .commit_pc   (commit_pc),
                .commit_inst (commit_inst),
                .commit_wen  (commit_wen),
                .commit_waddr(commit_waddr),
                .commit_wdata(commit_wdata),
                .out_valid   (ov[g]),
                .out_ready   (out_ready),
                .out_data    (od[g]),
                .out_beat    (ob[g]),
                .count       (c),
                .dropped     (dr[g]),
                .state       (st[g])
            );
            assign cnt[g] = 9'(c);
        end
    endgenerate

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        arm          = 1'b0;
        commit_valid = 1'b0;
        out_ready    = 1'b0;
        reset        = 1'b1;
        #2;
        reset        = 1'b0;
    endtask

    task automatic do_arm(input logic te, input logic [31:0] tp);
        arm     = 1'b1;
        trig_en = te;
        trig_pc = tp;
        step();
        arm     = 1'b0;
    endtask

    task automatic commit(input logic [31:0] pc, input logic [31:0] inst, input logic wen,
                          input logic [4:0] wa, input logic [31:0] wd);
        commit_pc    = pc;
        commit_inst  = inst;
        commit_wen   = wen;
        commit_waddr = wa;
        commit_wdata = wd;
        commit_valid = 1'b1;
        step();
        commit_valid = 1'b0;
    endtask

    initial begin
        int hs;
        #1 reset = 1'b1;
        #2;
        check("rst_state", st[0], 2'd0);
        check("rst_count", cnt[0], 9'd0);
        check("rst_valid", ov[0], 1'b0);
        check("rst_dropped", dr[0], 16'd0);
        step();
        reset = 1'b0;

        // Free-running capture of three commits, then full readout.
        do_arm(1'b0, 32'h0);
        check("t1_state", st[0], 2'd2);
        for (int k = 0; k < 3; k++) commit(32'(4 * k), 32'h1000 + 32'(4 * k), 1'b0, 5'd0, 32'h0);
        check("t1_count", cnt[0], 9'd3);
        hs = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!ov[0]) break;
            if (ob[0] == 2'd0) check("t1_beat0", od[0], 32'h00400000 + 32'(4 * (hs / 4)));
            if (hs == 1) check("t1_inst0", od[0], 32'h00001000);
            step();
            hs++;
        end
        out_ready = 1'b0;
        check("t1_handshakes", hs, 12);
        check("t1_count_end", cnt[0], 9'd0);

        // Triggered capture starting at pc 0x10.
        do_reset();
        do_arm(1'b1, 32'h10);
        check("t2_armed", st[0], 2'd1);
        for (int k = 0; k < 9; k++) begin
            commit(32'(4 * k), 32'h0, 1'b0, 5'd0, 32'h0);
            if (k == 3) check("t2_pre_trig_count", cnt[0], 9'd0);
            if (k == 4) check("t2_trig_state", st[0], 2'd2);
        end
        check("t2_count", cnt[0], 9'd5);
        check("t2_first_pc", od[0], 32'h00400010);
        check("t2_dropped", dr[0], 16'd0);

        // Overflow: stop (inst 1) versus overwrite (inst 2).
        do_reset();
        do_arm(1'b0, 32'h0);
        for (int k = 0; k < 6; k++) commit(32'h100 + 32'(4 * k), 32'h0, 1'b0, 5'd0, 32'h0);
        check("t3_stop_count", cnt[1], 9'd4);
        check("t3_stop_dropped", dr[1], 16'd2);
        check("t3_stop_state", st[1], 2'd3);
        check("t3_stop_oldest", od[1], 32'h00400100);
        check("t3_ovr_count", cnt[2], 9'd4);
        check("t3_ovr_dropped", dr[2], 16'd2);
        check("t3_ovr_state", st[2], 2'd2);
        check("t3_ovr_oldest", od[2], 32'h00400108);
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        check("t3_ovr_beat_mid", ob[2], 2'd2);
        commit(32'h118, 32'h0, 1'b0, 5'd0, 32'h0);
        check("t3_ovr_beat_restart", ob[2], 2'd0);
        check("t3_ovr_new_oldest", od[2], 32'h0040010C);
        check("t3_ovr_dropped2", dr[2], 16'd3);
        check("t3_stop_dropped_done", dr[1], 16'd3);
        check("t3_stop_beat_held", ob[1], 2'd2);
        out_ready = 1'b1;
        step();
        step();
        for (int r = 1; r < 4; r++) begin
            check("t3_stop_rec", od[1], 32'h00400100 + 32'(4 * r));
            for (int b = 0; b < 4; b++) step();
        end
        out_ready = 1'b0;
        check("t3_stop_drained", cnt[1], 9'd0);
        check("t3_stop_still_done", st[1], 2'd3);

        // Write into a full stop-mode buffer on the record-freeing cycle.
        do_reset();
        do_arm(1'b0, 32'h0);
        for (int k = 0; k < 4; k++) commit(32'h200 + 32'(4 * k), 32'h0, 1'b0, 5'd0, 32'h0);
        out_ready = 1'b1;
        step();
        step();
        step();
        commit(32'h210, 32'h0, 1'b0, 5'd0, 32'h0);
        out_ready = 1'b0;
        check("t4_count", cnt[1], 9'd4);
        check("t4_dropped", dr[1], 16'd0);
        check("t4_state", st[1], 2'd2);
        check("t4_oldest", od[1], 32'h00400204);

        // Backpressure hold and beat 2/3 encoding.
        do_reset();
        do_arm(1'b0, 32'h0);
        commit(32'h20, 32'h13, 1'b1, 5'd31, 32'hDEADBEEF);
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_data", od[0], 32'h8000001F);
            step();
        end
        check("t5_hold_beat", ob[0], 2'd2);
        out_ready = 1'b1;
        step();
        check("t5_beat3", od[0], 32'hDEADBEEF);
        step();
        out_ready = 1'b0;
        check("t5_drained", ov[0], 1'b0);

        // Asynchronous reset in the middle of a readout.
        do_reset();
        do_arm(1'b0, 32'h0);
        commit(32'h40, 32'h0, 1'b0, 5'd0, 32'h0);
        commit(32'h44, 32'h0, 1'b0, 5'd0, 32'h0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t6_pre_beat", ob[0], 2'd1);
        check("t6_pre_count", cnt[0], 9'd2);
        #2 reset = 1'b1;
        #1;
        check("t6_state", st[0], 2'd0);
        check("t6_count", cnt[0], 9'd0);
        check("t6_valid", ov[0], 1'b0);
        check("t6_beat", ob[0], 2'd0);
        #2 reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
